// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch-stage program counter register with stall hold
//
// Holds the current instruction address. On each qualifying rising edge it
// captures the next-PC value selected upstream, so the block needs no adder.
//
// Ports:
//   clk    in   1      system clock, rising-edge active
//   rst    in   1      asynchronous reset, active-low (0 = reset asserted)
//   hazrd  in   1      stall: 1 = hold current PC, 0 = load PCin
//   PCin   in   WIDTH  next program counter value from the next-PC mux
//   PCout  out  WIDTH  current program counter, driven straight from the register

module program_counter #(
  parameter int                 WIDTH       = 16,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazrd,
  input  logic [WIDTH-1:0] PCin,
  output logic [WIDTH-1:0] PCout
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // A stall recirculates the held address; otherwise the upstream value is
  // taken verbatim, including all-ones, with no alignment or increment.
  always_comb begin
    pc_d = pc_q;
    if (!hazrd) begin
      pc_d = PCin;
    end
  end

  // Reset overrides both load and stall and acts without a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_VALUE;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Registered output only: no combinational path from PCin or hazrd.
  assign PCout = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - self-checking bench for program_counter

module tb_program_counter;

  logic        clk;
  logic        rst;
  logic        hazrd;
  logic [15:0] PCin;
  logic [15:0] PCout;

  int          checks;
  int          fails;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  program_counter #(
    .WIDTH      (16),
    .RESET_VALUE(16'h0000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .hazrd(hazrd),
    .PCin (PCin),
    .PCout(PCout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, PCout=%h", PCout);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst   = 1'b1;
    hazrd = 1'b0;
    PCin  = 16'hFFFF;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (PCout !== 16'h0000) begin
      fails++;
      $display("FAIL reset_async_initial: PCout=%h expected=%h", PCout, 16'h0000);
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(16'h0000);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (PCout !== exp_v) begin
        fails++;
        $display("FAIL reset_hold_edge%0d: PCout=%h expected=%h", i, PCout, exp_v);
      end
    end
    rst  = 1'b1;
    PCin = 16'h1234;
    exp_q.push_back(16'h1234);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (PCout !== exp_v) begin
      fails++;
      $display("FAIL reset_preload: PCout=%h expected=%h", PCout, exp_v);
    end
    #5 rst = 1'b0;
    #1;
    checks++;
    if (PCout !== 16'h0000) begin
      fails++;
      $display("FAIL reset_midcycle: PCout=%h expected=%h", PCout, 16'h0000);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    rst   = 1'b1;
    hazrd = 1'b0;
    PCin  = 16'hFFFF;
    exp_q.push_back(16'hFFFF);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (PCout !== exp_v) begin
      fails++;
      $display("FAIL load_ffff: PCout=%h expected=%h", PCout, exp_v);
    end
    PCin = 16'h1234;
    exp_q.push_back(16'h1234);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (PCout !== exp_v) begin
      fails++;
      $display("FAIL load_1234: PCout=%h expected=%h", PCout, exp_v);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    hazrd = 1'b0;
    PCin  = 16'hFFFF;
    exp_q.push_back(16'hFFFF);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (PCout !== exp_v) begin
      fails++;
      $display("FAIL stall_preload: PCout=%h expected=%h", PCout, exp_v);
    end
    hazrd = 1'b1;
    PCin  = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(16'hFFFF);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (PCout !== exp_v) begin
        fails++;
        $display("FAIL stall_hold_edge%0d: PCout=%h expected=%h", i, PCout, exp_v);
      end
    end
    hazrd = 1'b0;
    exp_q.push_back(16'h1234);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (PCout !== exp_v) begin
      fails++;
      $display("FAIL stall_release: PCout=%h expected=%h", PCout, exp_v);
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    hazrd = 1'b0;
    PCin  = 16'h0000;
    exp_q.push_back(16'h0000);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (PCout !== exp_v) begin
      fails++;
      $display("FAIL glitch_preload: PCout=%h expected=%h", PCout, exp_v);
    end
    PCin = 16'hFFFF;
    exp_q.push_back(16'hFFFF);
    #4 hazrd = 1'b1;
    #10 hazrd = 1'b0;
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (PCout !== exp_v) begin
      fails++;
      $display("FAIL glitch_load: PCout=%h expected=%h", PCout, exp_v);
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (PCout !== 16'h0000) begin
      fails++;
      $display("FAIL release_assert: PCout=%h expected=%h", PCout, 16'h0000);
    end
    hazrd = 1'b0;
    PCin  = 16'hABCD;
    @(posedge clk);
    #5 rst = 1'b1;
    #1;
    checks++;
    if (PCout !== 16'h0000) begin
      fails++;
      $display("FAIL release_no_change: PCout=%h expected=%h", PCout, 16'h0000);
    end
    exp_q.push_back(16'hABCD);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (PCout !== exp_v) begin
      fails++;
      $display("FAIL release_first_load: PCout=%h expected=%h", PCout, exp_v);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    rst   = 1'b1;
    hazrd = 1'b0;
    PCin  = 16'h1111;
    exp_q.push_back(16'h1111);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (PCout !== exp_v) begin
      fails++;
      $display("FAIL priority_preload: PCout=%h expected=%h", PCout, exp_v);
    end
    @(negedge clk);
    rst   = 1'b0;
    hazrd = 1'b0;
    PCin  = 16'h5555;
    exp_q.push_back(16'h0000);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (PCout !== exp_v) begin
      fails++;
      $display("FAIL priority_reset_over_load: PCout=%h expected=%h", PCout, exp_v);
    end
    rst   = 1'b1;
    hazrd = 1'b1;
    exp_q.push_back(16'h0000);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (PCout !== exp_v) begin
      fails++;
      $display("FAIL priority_stall_after_reset: PCout=%h expected=%h", PCout, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] model_pc;
    logic [15:0] pc_val;
    logic        hz;
    model_pc = 16'h0000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pc_val = (i == 7) ? 16'hFFFF : 16'($urandom);
      hz     = ($urandom_range(0, 3) == 0);
      rst    = 1'b1;
      hazrd  = hz;
      PCin   = pc_val;
      if (!hz) model_pc = pc_val;
      exp_q.push_back(model_pc);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (PCout !== exp_v) begin
        fails++;
        $display("FAIL b2b_cycle%0d: PCout=%h expected=%h (hazrd=%0b PCin=%h)", i, PCout, exp_v, hz, pc_val);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_load();
    test_stall();
    test_glitch();
    test_release();
    test_priority();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: leftover=%0d expected=%0d", exp_q.size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 16-bit program counter register at the head of the fetch stage.
- Each rising clock edge it loads the next-PC value computed upstream (increment, branch or jump target mux) and presents it to instruction memory.
- A hazard/stall input freezes the register so the pipeline can hold the current instruction address.
- Pure register block: no adder inside; next-PC selection lives outside.

Parameters:
- WIDTH, 16, bit width of PCin and PCout.
- RESET_VALUE, 16'h0000, value PCout takes while reset is asserted (must fit in WIDTH bits).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- hazrd  input  1  hazard/stall; 1 = hold current PC, 0 = load PCin.
- PCin  input  WIDTH  next program counter value from the next-PC mux.
- PCout  output  WIDTH  current program counter, registered.

Behaviour:
- Single WIDTH-bit register drives PCout directly. No combinational path from PCin or hazrd to PCout.
- Reset:
  - rst falling to 0 forces PCout = RESET_VALUE immediately, without waiting for a clock edge.
  - PCout holds RESET_VALUE for as long as rst = 0, regardless of clk, hazrd or PCin.
- Reset release:
  - rst rising to 1 does not change PCout.
  - The first load occurs on the first rising clk edge with rst = 1 and hazrd = 0.
- Normal load: at a rising clk edge with rst = 1 and hazrd = 0, PCout <= PCin. Latency is one edge; the new value is visible after the edge.
- Stall: at a rising clk edge with rst = 1 and hazrd = 1, PCout keeps its previous value. PCin is ignored.
- hazrd is sampled only at the rising edge. Pulses that start and end between edges have no effect.
- PCin changes between edges have no effect until the next qualifying edge.
- Reset has priority over hazrd and over load. Reset asserted in the same cycle as a stall or load yields RESET_VALUE.
- Width: PCin is loaded verbatim, with no truncation, alignment or increment. All-ones (16'hFFFF) is a legal value and is stored as-is. No wrap logic is needed because no arithmetic is performed.
- X-handling: PCout must never be X after reset has been asserted at least once.

Test Plan:
- Reset:
  - Hold rst = 0 with PCin = 16'hFFFF, toggle clk for 3 edges -> PCout = 16'h0000 throughout.
  - Assert rst = 0 mid-cycle while PCout = 16'h1234 -> PCout = 16'h0000 before the next edge.
- Load: rst = 1, hazrd = 0, PCin = 16'hFFFF, one rising edge -> PCout = 16'hFFFF. Then PCin = 16'h1234, next edge -> PCout = 16'h1234.
- Stall: PCout = 16'hFFFF, set hazrd = 1 and PCin = 16'h1234 across 2 edges -> PCout stays 16'hFFFF. Drop hazrd to 0 -> next edge PCout = 16'h1234.
- Glitch immunity: pulse hazrd = 1 for 10 ns entirely between two rising edges (20 ns period), with PCin = 16'hFFFF -> the following edge loads normally, PCout = 16'hFFFF.
- Release timing: deassert rst 5 ns after a rising edge with PCin = 16'hABCD -> PCout stays 16'h0000 until the next rising edge, then becomes 16'hABCD.
- Priority: rst = 0 and hazrd = 0 with PCin = 16'h5555 at a rising edge -> PCout = 16'h0000. Then rst = 1 and hazrd = 1 -> PCout remains 16'h0000 on the next edge.
